user_stream_splitter7: RTL and testbench
========================================

Name: user_stream_splitter7

Overview:
- User-side endpoint for a leaf with one input port and seven output ports.
- Consumes the interface-to-user stream on port 1 (vld/ack) and routes each packet to one of seven user-to-interface output streams.
- Routing is taken from a header word at the start of each packet.
- Sits inside the user kernel, between the leaf interface's user-facing ports and the user compute logic. It also serves as a standalone routing kernel for bring-up.

Parameters:
- PAYLOAD_BITS, 32, stream word width.
- LEN_BITS, 16, width of the header length field (header bits [LEN_BITS-1:0]).
- DEST_LSB, 29, LSB of the 3-bit destination field (header bits [DEST_LSB+2:DEST_LSB]).
- ERR_CNT_BITS, 16, width of the saturating drop counter.

Ports:
- clk_user  in  1  user clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- dout_leaf_interface2user_1  in  PAYLOAD_BITS  input stream data.
- vld_interface2user_1  in  1  input word valid.
- ack_user2interface_1  out  1  input accept.
- din_leaf_user2interface_k (k=1..7)  out  PAYLOAD_BITS  output stream data, port k.
- vld_user2interface_k (k=1..7)  out  1  output valid, port k.
- ack_interface2user_k (k=1..7)  in  1  output accept, port k.
- drop_count  out  ERR_CNT_BITS  saturating count of packets dropped for bad destination.
- busy  out  1  high while state is not HDR.

Behaviour:
- Clocking and reset: one clock, clk_user. Reset is synchronous and active-high. While reset is sampled high:
  - state=HDR, remaining count=0, drop_count=0.
  - All vld_user2interface_k=0, all din_leaf_user2interface_k=0.
  - ack_user2interface_1=0.
- Handshake rule, both sides: a word transfers on a clk_user edge where vld and ack are both 1.
  - Producer holds data and vld stable until the transfer.
  - ack may be high without vld.
  - vld never depends combinationally on ack.
- Header format:
  - dest = hdr[DEST_LSB+2:DEST_LSB]; values 0..6 select output port dest+1, value 7 is invalid.
  - len = hdr[LEN_BITS-1:0] is the payload word count. The header itself is never forwarded.
- State machine:
  - HDR:
    - ack_user2interface_1=1.
    - On transfer, latch dest and len.
    - len==0 → stay in HDR (empty packet; also increments drop_count if dest==7).
    - dest==7 and len>0 → DROP. drop_count increments on header accept.
    - Otherwise → FWD.
  - FWD:
    - ack_user2interface_1 = !vld_user2interface_{dest+1} || ack_interface2user_{dest+1}. This is combinational from the selected output's ack, giving full throughput.
    - On transfer, the word loads into that port's output register and remaining decrements.
    - After the last word (remaining==1 at transfer) → HDR.
  - DROP:
    - ack_user2interface_1=1; words are discarded.
    - After the last word → HDR.
- Latency and throughput:
  - A payload word accepted at edge t is visible on din/vld of its port after edge t (one register).
  - Sustained rate is 1 word/cycle while the destination acks.
  - Each header costs one input cycle.
- Output registers: one entry per port.
  - Set on load.
  - Clear on ack with no simultaneous load.
  - Load and ack in the same cycle → register replaced and vld stays 1.
  - Outputs of non-selected ports keep draining independently while another port is being fed.
- drop_count saturates at all-ones; no wrap.
- Back-pressure: if the destination holds ack low with vld high, input ack stays low and no word is lost or duplicated.
- Reset mid-packet: partial packet is abandoned, and output registers are cleared even if vld was high. The next input word after reset is treated as a header.
- Width rules: len is LEN_BITS unsigned; max payload per packet is 2^LEN_BITS-1.

Decomposition:
- Package user_stream_pkg holds:
  - state enum {HDR, FWD, DROP};
  - localparams NUM_OUT_PORTS=7, DEST_BITS=3, DEST_INVALID=3'd7;
  - header field extraction functions.
- One sub-module, out_reg_slice: a one-entry valid/ack register with load, data and ack inputs, instantiated seven times.

Test Plan:
- Header {dest=2, len=3} then 0xA1,0xA2,0xA3, all acks high → port 3 emits 0xA1..0xA3 on consecutive cycles, each one cycle after input accept; the other ports' vld stay 0; busy returns 0 after the third word.
- Header {dest=7, len=4} + 4 words → no output vld on any port, input ack high throughout, drop_count 0→1.
- Header {dest=0, len=2}, ack_interface2user_1 held low 5 cycles during the first word → port 1 vld held with 0x..first word, ack_user2interface_1 low; after release both words are delivered in order with no loss or duplication.
- Back-to-back packets: {dest=4, len=1},0x55 then {dest=5, len=1},0x66 → port 5 gets 0x55 and port 6 gets 0x66; port 5 holding (its ack low) does not block port 6.
- Header {dest=1, len=0} followed by header {dest=6, len=1},0x77 → nothing on port 2; port 7 gets 0x77.
- Reset asserted after 2 of 5 payload words → all vld 0 and drop_count 0 next cycle; the next word {dest=3, len=1},0x99 is routed as a header and 0x99 appears on port 4.

Source files
------------

// File: rtl/user_stream_pkg.sv
// Shared types, constants and header field helpers for the seven-way stream splitter.
// Pure declarations: no latency, no flow control.
package user_stream_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int                   NUM_OUT_PORTS = 7;
    localparam int                   DEST_BITS     = 3;
    localparam logic [DEST_BITS-1:0] DEST_INVALID  = 3'd7;

    // Widest header word the helpers handle; callers zero-extend into this.
    localparam int HDR_MAX_BITS = 64;

    function automatic logic [DEST_BITS-1:0] hdr_dest(input logic [HDR_MAX_BITS-1:0] hdr,
                                                      input int dest_lsb);
        return hdr[dest_lsb +: DEST_BITS];
    endfunction

    function automatic logic [HDR_MAX_BITS-1:0] hdr_len(input logic [HDR_MAX_BITS-1:0] hdr,
                                                        input int len_bits);
        return hdr & ((HDR_MAX_BITS'(1) << len_bits) - HDR_MAX_BITS'(1));
    endfunction

endpackage

// File: rtl/user_stream_splitter7_if.sv
// Leaf-side stream bundle: one interface-to-user input, seven user-to-interface outputs.
// master = splitter side, slave = leaf interface / testbench side.
interface user_stream_splitter7_if #(
    parameter int PAYLOAD_BITS = 32
);
    logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_1;
    logic                    vld_interface2user_1;
    logic                    ack_user2interface_1;

    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_1;
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_2;
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_3;
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_4;
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_5;
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_6;
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_7;

    logic vld_user2interface_1, vld_user2interface_2, vld_user2interface_3, vld_user2interface_4;
    logic vld_user2interface_5, vld_user2interface_6, vld_user2interface_7;

    logic ack_interface2user_1, ack_interface2user_2, ack_interface2user_3, ack_interface2user_4;
    logic ack_interface2user_5, ack_interface2user_6, ack_interface2user_7;

    modport master (
        input  dout_leaf_interface2user_1, vld_interface2user_1,
        output ack_user2interface_1,
        output din_leaf_user2interface_1, din_leaf_user2interface_2, din_leaf_user2interface_3,
               din_leaf_user2interface_4, din_leaf_user2interface_5, din_leaf_user2interface_6,
               din_leaf_user2interface_7,
        output vld_user2interface_1, vld_user2interface_2, vld_user2interface_3,
               vld_user2interface_4, vld_user2interface_5, vld_user2interface_6,
               vld_user2interface_7,
        input  ack_interface2user_1, ack_interface2user_2, ack_interface2user_3,
               ack_interface2user_4, ack_interface2user_5, ack_interface2user_6,
               ack_interface2user_7
    );

    modport slave (
        output dout_leaf_interface2user_1, vld_interface2user_1,
        input  ack_user2interface_1,
        input  din_leaf_user2interface_1, din_leaf_user2interface_2, din_leaf_user2interface_3,
               din_leaf_user2interface_4, din_leaf_user2interface_5, din_leaf_user2interface_6,
               din_leaf_user2interface_7,
        input  vld_user2interface_1, vld_user2interface_2, vld_user2interface_3,
               vld_user2interface_4, vld_user2interface_5, vld_user2interface_6,
               vld_user2interface_7,
        output ack_interface2user_1, ack_interface2user_2, ack_interface2user_3,
               ack_interface2user_4, ack_interface2user_5, ack_interface2user_6,
               ack_interface2user_7
    );

endinterface

// File: rtl/out_reg_slice.sv
// One-entry output register for a vld/ack stream; load wins over ack when both occur.
// Latency 1 cycle from load; holds data and vld until the consumer acks.
module out_reg_slice #(
    parameter int PAYLOAD_BITS = 32
) (
    input  logic                    clk_user,
    input  logic                    reset,
    input  logic                    load,
    input  logic [PAYLOAD_BITS-1:0] load_dat,
    input  logic                    ack,
    output logic                    vld,
    output logic [PAYLOAD_BITS-1:0] dat
);

    always_ff @(posedge clk_user) begin
        if (reset) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (load) begin
            vld <= 1'b1;
            dat <= load_dat;
        end else if (ack) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/user_stream_splitter7.sv
// Routes each header-prefixed packet on the input stream to one of seven output streams.
// Payload latency 1 cycle; input ack follows the selected port's ack so stalls never drop words.
module user_stream_splitter7
    import user_stream_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int LEN_BITS     = 16,
    parameter int DEST_LSB     = 29,
    parameter int ERR_CNT_BITS = 16
) (
    input  logic                    clk_user,
    input  logic                    reset,
    user_stream_splitter7_if.master bus,
    output logic [ERR_CNT_BITS-1:0] drop_count,
    output logic                    busy
);

    state_t                    state;
    logic [DEST_BITS-1:0]      dest;
    logic [LEN_BITS-1:0]       remaining;

    logic [HDR_MAX_BITS-1:0]   hdr_ext;
    logic [DEST_BITS-1:0]      hdr_dst;
    logic [LEN_BITS-1:0]       hdr_ln;

    logic [NUM_OUT_PORTS-1:0]  sel_oh;
    logic [NUM_OUT_PORTS-1:0]  out_vld;
    logic [NUM_OUT_PORTS-1:0]  out_ack;
    logic [NUM_OUT_PORTS-1:0]  out_load;
    logic [PAYLOAD_BITS-1:0]   out_dat [NUM_OUT_PORTS];

    logic                      in_ack;
    logic                      in_xfer;

    assign hdr_ext = HDR_MAX_BITS'(bus.dout_leaf_interface2user_1);
    assign hdr_dst = hdr_dest(hdr_ext, DEST_LSB);
    assign hdr_ln  = LEN_BITS'(hdr_len(hdr_ext, LEN_BITS));

    // An invalid destination never reaches FWD, so an empty select is only a safety net.
    assign sel_oh = (dest == DEST_INVALID) ? '0 : (NUM_OUT_PORTS'(1) << dest);

    assign out_ack = {bus.ack_interface2user_7, bus.ack_interface2user_6,
                      bus.ack_interface2user_5, bus.ack_interface2user_4,
                      bus.ack_interface2user_3, bus.ack_interface2user_2,
                      bus.ack_interface2user_1};

    always_comb begin
        in_ack = 1'b0;
        if (!reset) begin
            case (state)
                HDR:     in_ack = 1'b1;
                DROP:    in_ack = 1'b1;
                FWD:     in_ack = |(sel_oh & (~out_vld | out_ack));
                default: in_ack = 1'b0;
            endcase
        end
    end

    assign bus.ack_user2interface_1 = in_ack;
    assign in_xfer  = bus.vld_interface2user_1 & in_ack;
    assign out_load = (state == FWD && in_xfer) ? sel_oh : '0;
    assign busy     = (state != HDR);

    always_ff @(posedge clk_user) begin
        if (reset) begin
            state      <= HDR;
            dest       <= '0;
            remaining  <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                HDR: begin
                    if (in_xfer) begin
                        dest      <= hdr_dst;
                        remaining <= hdr_ln;
                        if (hdr_dst == DEST_INVALID && drop_count != '1) begin
                            drop_count <= drop_count + ERR_CNT_BITS'(1);
                        end
                        if (hdr_ln == '0) begin
                            state <= HDR;
                        end else if (hdr_dst == DEST_INVALID) begin
                            state <= DROP;
                        end else begin
                            state <= FWD;
                        end
                    end
                end
                FWD, DROP: begin
                    if (in_xfer) begin
                        remaining <= remaining - LEN_BITS'(1);
                        if (remaining == LEN_BITS'(1)) begin
                            state <= HDR;
                        end
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
        out_reg_slice #(
            .PAYLOAD_BITS(PAYLOAD_BITS)
        ) u_slice (
            .clk_user (clk_user),
            .reset    (reset),
            .load     (out_load[k]),
            .load_dat (bus.dout_leaf_interface2user_1),
            .ack      (out_ack[k]),
            .vld      (out_vld[k]),
            .dat      (out_dat[k])
        );
    end

    assign bus.vld_user2interface_1 = out_vld[0];
    assign bus.vld_user2interface_2 = out_vld[1];
    assign bus.vld_user2interface_3 = out_vld[2];
    assign bus.vld_user2interface_4 = out_vld[3];
    assign bus.vld_user2interface_5 = out_vld[4];
    assign bus.vld_user2interface_6 = out_vld[5];
    assign bus.vld_user2interface_7 = out_vld[6];

    assign bus.din_leaf_user2interface_1 = out_dat[0];
    assign bus.din_leaf_user2interface_2 = out_dat[1];
    assign bus.din_leaf_user2interface_3 = out_dat[2];
    assign bus.din_leaf_user2interface_4 = out_dat[3];
    assign bus.din_leaf_user2interface_5 = out_dat[4];
    assign bus.din_leaf_user2interface_6 = out_dat[5];
    assign bus.din_leaf_user2interface_7 = out_dat[6];

endmodule

// File: tb/tb_user_stream_splitter7.sv
// Directed bench for the seven-way splitter: routing, drop, stall, back-to-back, empty and reset cases.
module tb_user_stream_splitter7;

    logic        clk_user = 1'b0;
    logic        reset;
    logic [15:0] drop_count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    user_stream_splitter7_if #(.PAYLOAD_BITS(32)) bus ();

    user_stream_splitter7 #(
        .PAYLOAD_BITS (32),
        .LEN_BITS     (16),
        .DEST_LSB     (29),
        .ERR_CNT_BITS (16)
    ) dut (
        .clk_user   (clk_user),
        .reset      (reset),
        .bus        (bus),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk_user = ~clk_user;

    logic [6:0]  o_vld;
    logic [6:0]  o_ack;
    logic [31:0] o_dat [7];

    assign o_vld = {bus.vld_user2interface_7, bus.vld_user2interface_6, bus.vld_user2interface_5,
                    bus.vld_user2interface_4, bus.vld_user2interface_3, bus.vld_user2interface_2,
                    bus.vld_user2interface_1};
    assign o_dat[0] = bus.din_leaf_user2interface_1;
    assign o_dat[1] = bus.din_leaf_user2interface_2;
    assign o_dat[2] = bus.din_leaf_user2interface_3;
    assign o_dat[3] = bus.din_leaf_user2interface_4;
    assign o_dat[4] = bus.din_leaf_user2interface_5;
    assign o_dat[5] = bus.din_leaf_user2interface_6;
    assign o_dat[6] = bus.din_leaf_user2interface_7;
    assign bus.ack_interface2user_1 = o_ack[0];
    assign bus.ack_interface2user_2 = o_ack[1];
    assign bus.ack_interface2user_3 = o_ack[2];
    assign bus.ack_interface2user_4 = o_ack[3];
    assign bus.ack_interface2user_5 = o_ack[4];
    assign bus.ack_interface2user_6 = o_ack[5];
    assign bus.ack_interface2user_7 = o_ack[6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word at a negedge, wait (bounded) for ack, return at the negedge after the transfer.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        bus.vld_interface2user_1       = 1'b1;
        bus.dout_leaf_interface2user_1 = w;
        #1;
        while (bus.ack_user2interface_1 !== 1'b1 && n < 20) begin
            @(negedge clk_user);
            #1;
            n++;
        end
        chk("send_ack", 32'(bus.ack_user2interface_1), 32'd1);
        @(negedge clk_user);
        bus.vld_interface2user_1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.vld_interface2user_1       = 1'b0;
        bus.dout_leaf_interface2user_1 = '0;
        o_ack = 7'h7f;
        repeat (2) @(negedge clk_user);

        // Reset state
        chk("rst_vld",    32'(o_vld), 32'd0);
        chk("rst_drop",   32'(drop_count), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_in_ack", 32'(bus.ack_user2interface_1), 32'd0);
        chk("rst_dat1",   o_dat[0], 32'd0);
        reset = 1'b0;

        // dest=2 len=3 -> port 3, one cycle after each accept
        send(32'h4000_0003);
        chk("t1_busy_hdr", 32'(busy), 32'd1);
        chk("t1_vld_hdr",  32'(o_vld), 32'd0);
        send(32'h0000_00A1);
        chk("t1_vld_a1", 32'(o_vld), 32'h04);
        chk("t1_dat_a1", o_dat[2], 32'h0000_00A1);
        send(32'h0000_00A2);
        chk("t1_vld_a2", 32'(o_vld), 32'h04);
        chk("t1_dat_a2", o_dat[2], 32'h0000_00A2);
        send(32'h0000_00A3);
        chk("t1_vld_a3",  32'(o_vld), 32'h04);
        chk("t1_dat_a3",  o_dat[2], 32'h0000_00A3);
        chk("t1_busy_end", 32'(busy), 32'd0);
        @(negedge clk_user);
        chk("t1_drained", 32'(o_vld), 32'd0);

        // dest=7 len=4 -> dropped, input ack high throughout
        send(32'hE000_0004);
        chk("t2_drop_cnt", 32'(drop_count), 32'd1);
        chk("t2_busy",     32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.vld_interface2user_1       = 1'b1;
            bus.dout_leaf_interface2user_1 = 32'hD0 + 32'(i);
            #1;
            chk("t2_in_ack", 32'(bus.ack_user2interface_1), 32'd1);
            @(negedge clk_user);
            chk("t2_no_vld", 32'(o_vld), 32'd0);
        end
        bus.vld_interface2user_1 = 1'b0;
        chk("t2_busy_end", 32'(busy), 32'd0);
        chk("t2_drop_end", 32'(drop_count), 32'd1);

        // dest=0 len=2 with port 1 stalled for 5 cycles
        o_ack[0] = 1'b0;
        send(32'h0000_0002);
        send(32'h0000_00B1);
        chk("t3_vld_b1", 32'(o_vld), 32'h01);
        chk("t3_dat_b1", o_dat[0], 32'h0000_00B1);
        bus.vld_interface2user_1       = 1'b1;
        bus.dout_leaf_interface2user_1 = 32'h0000_00B2;
        #1;
        chk("t3_stall_ack0", 32'(bus.ack_user2interface_1), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_user);
            #1;
            chk("t3_hold_vld", 32'(o_vld), 32'h01);
            chk("t3_hold_dat", o_dat[0], 32'h0000_00B1);
            chk("t3_hold_ack", 32'(bus.ack_user2interface_1), 32'd0);
        end
        o_ack[0] = 1'b1;
        #1;
        chk("t3_release_ack", 32'(bus.ack_user2interface_1), 32'd1);
        @(negedge clk_user);
        bus.vld_interface2user_1 = 1'b0;
        chk("t3_vld_b2",  32'(o_vld), 32'h01);
        chk("t3_dat_b2",  o_dat[0], 32'h0000_00B2);
        chk("t3_busy",    32'(busy), 32'd0);
        @(negedge clk_user);
        chk("t3_drained", 32'(o_vld), 32'd0);

        // back-to-back: port 5 held, port 6 still fed and drains
        o_ack[4] = 1'b0;
        send(32'h8000_0001);
        send(32'h0000_0055);
        chk("t4_vld_55", 32'(o_vld), 32'h10);
        chk("t4_dat_55", o_dat[4], 32'h0000_0055);
        send(32'hA000_0001);
        send(32'h0000_0066);
        chk("t4_vld_both", 32'(o_vld), 32'h30);
        chk("t4_dat_66",   o_dat[5], 32'h0000_0066);
        chk("t4_dat_55b",  o_dat[4], 32'h0000_0055);
        @(negedge clk_user);
        chk("t4_p6_drain", 32'(o_vld), 32'h10);
        o_ack[4] = 1'b1;
        @(negedge clk_user);
        chk("t4_p5_drain", 32'(o_vld), 32'd0);

        // empty packet to port 2, then dest=6 len=1
        send(32'h2000_0000);
        chk("t5_busy_empty", 32'(busy), 32'd0);
        chk("t5_vld_empty",  32'(o_vld), 32'd0);
        chk("t5_drop_same",  32'(drop_count), 32'd1);
        send(32'hC000_0001);
        chk("t5_busy_fwd", 32'(busy), 32'd1);
        send(32'h0000_0077);
        chk("t5_vld_77", 32'(o_vld), 32'h40);
        chk("t5_dat_77", o_dat[6], 32'h0000_0077);
        @(negedge clk_user);
        chk("t5_drained", 32'(o_vld), 32'd0);

        // reset after 2 of 5 payload words
        send(32'h0000_0005);
        send(32'h0000_00C1);
        send(32'h0000_00C2);
        chk("t6_vld_pre", 32'(o_vld), 32'h01);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_ack", 32'(bus.ack_user2interface_1), 32'd0);
        @(negedge clk_user);
        chk("t6_rst_vld",  32'(o_vld), 32'd0);
        chk("t6_rst_drop", 32'(drop_count), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_dat",  o_dat[0], 32'd0);
        reset = 1'b0;
        send(32'h6000_0001);
        chk("t6_busy_hdr", 32'(busy), 32'd1);
        send(32'h0000_0099);
        chk("t6_vld_99", 32'(o_vld), 32'h08);
        chk("t6_dat_99", o_dat[3], 32'h0000_0099);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
